// File: rtl/dmem_arbiter.sv
// Two-port arbiter and command sequencer for the 1024-byte data memory.
// Port 0 (MEM stage) has priority; port 1 (debug/loader) is protected from starvation.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_BYTES    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [32:0] MEM_TOP = 33'(MEM_BYTES);

  logic [3:0]  starve_q, starve_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        a_valid_q, a_valid_d;
  logic        a_id_q, a_id_d;
  logic        b_valid_q, b_valid_d;
  logic        b_id_q, b_id_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;

  logic        xfer;
  logic        legal;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Grants are held off during reset so nothing is accepted while the flops are cleared.
  always_comb begin
    gnt1 = rst_n & req1 & (~req0 | (starve_q == LIMIT));
    gnt0 = rst_n & req0 & ~gnt1;
  end

  always_comb begin
    xfer      = gnt0 | gnt1;
    sel_we    = gnt1 ? we1 : we0;
    sel_addr  = gnt1 ? addr1 : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    legal     = ({1'b0, sel_addr} + 33'd3) < MEM_TOP;
  end

  always_comb begin
    starve_d = starve_q;
    if (!req1 || gnt1)
      starve_d = '0;
    else if (starve_q < LIMIT)
      starve_d = starve_q + 4'd1;

    mem_read_d  = xfer & legal & ~sel_we;
    mem_write_d = xfer & legal & sel_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (xfer && legal) begin
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
    end

    a_valid_d = xfer & legal & ~sel_we;
    a_id_d    = gnt1;
    b_valid_d = a_valid_q;
    b_id_d    = a_id_q;

    err0_d = gnt0 & ~legal;
    err1_d = gnt1 & ~legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_valid_q   <= 1'b0;
      a_id_q      <= 1'b0;
      b_valid_q   <= 1'b0;
      b_id_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_valid_q   <= a_valid_d;
      a_id_q      <= a_id_d;
      b_valid_q   <= b_valid_d;
      b_id_q      <= b_id_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
    end
  end

  always_comb begin
    mem_read  = mem_read_q;
    mem_write = mem_write_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    err0      = err0_q;
    err1      = err1_q;
    rvalid0   = b_valid_q & ~b_id_q;
    rvalid1   = b_valid_q & b_id_q;
    rdata     = b_valid_q ? mem_rdata : '0;
  end

endmodule
